branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit_if.sv | 43 ++++
 rtl/branch_predict_unit.sv | 137 +++++++++++++
 tb/tb_branch_predict_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute bus of the branch predict unit: fetch-side prediction and
// execute-side resolve/train signals, plus the statistics counters.
interface branch_predict_unit_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
);
    // Handshake: ex_valid qualifies every ex_* input in the cycle it is high;
    // there is no ready, the unit accepts one instruction per cycle, and all
    // outputs are combinational responses to the current inputs and state.
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_pc;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [PC_W-1:0]  ex_pc_plus_2;
    logic             ex_branch_imm;
    logic             ex_branch_reg;
    logic [IMM_W-1:0] ex_imm;
    logic [2:0]       ex_cc;
    logic [2:0]       ex_flag;
    logic [PC_W-1:0]  ex_reg_data;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_pc;
    logic             stat_clr;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, ex_pc_plus_2, ex_branch_imm, ex_branch_reg,
               ex_imm, ex_cc, ex_flag, ex_reg_data, ex_pred_taken, ex_pred_pc, stat_clr,
        output pred_taken, pred_pc, ex_taken, ex_target, mispredict, br_cnt, mp_cnt
    );

    modport master (
        output fetch_pc, ex_valid, ex_pc, ex_pc_plus_2, ex_branch_imm, ex_branch_reg,
               ex_imm, ex_cc, ex_flag, ex_reg_data, ex_pred_taken, ex_pred_pc, stat_clr,
        input  pred_taken, pred_pc, ex_taken, ex_target, mispredict, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch unit: BHT/BTB prediction at fetch, condition resolve, mispredict
// detection and table training at execute, plus saturating statistics.
module branch_predict_unit #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       ctr_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PC_W-1:0]  tgt_q [DEPTH];
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;

    // Fetch-side lookup: reads registered table state only, so a training
    // write to the same index becomes visible the following cycle.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;

    assign f_idx   = bus.fetch_pc[IDX_W:1];
    assign f_tag   = bus.fetch_pc[PC_W-1:IDX_W+1];
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit & ctr_q[f_idx][1];

    assign bus.pred_taken = f_taken;
    assign bus.pred_pc    = f_taken ? tgt_q[f_idx] : bus.fetch_pc + PC_W'(2);

    logic flag_n, flag_z, flag_v;
    logic cond;

    assign flag_n = bus.ex_flag[2];
    assign flag_z = bus.ex_flag[1];
    assign flag_v = bus.ex_flag[0];

    always_comb begin
        cond = 1'b0;
        case (bus.ex_cc)
            3'b000:  cond = ~flag_z;
            3'b001:  cond = flag_z;
            3'b010:  cond = ~flag_z & ~flag_n;
            3'b011:  cond = flag_n;
            3'b100:  cond = flag_z | ~flag_n;
            3'b101:  cond = flag_z | flag_n;
            3'b110:  cond = flag_v;
            default: cond = 1'b1;
        endcase
    end

    logic            is_br;
    logic            taken;
    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] imm_tgt;
    logic [PC_W-1:0] br_tgt;
    logic            mp;

    assign is_br    = bus.ex_valid & (bus.ex_branch_imm | bus.ex_branch_reg);
    assign taken    = is_br & cond;
    assign imm_sext = PC_W'($signed(bus.ex_imm));
    assign imm_tgt  = bus.ex_pc_plus_2 + {imm_sext[PC_W-2:0], 1'b0};
    // PC-relative takes priority when both branch kinds are flagged.
    assign br_tgt   = bus.ex_branch_imm ? imm_tgt : bus.ex_reg_data;
    assign mp       = bus.ex_valid &
                      ((taken != bus.ex_pred_taken) |
                       (taken & (br_tgt != bus.ex_pred_pc)));

    assign bus.ex_taken   = taken;
    assign bus.ex_target  = taken ? br_tgt : bus.ex_pc_plus_2;
    assign bus.mispredict = mp;

    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             unused_ex_pc_lsb;

    assign e_idx            = bus.ex_pc[IDX_W:1];
    assign e_tag            = bus.ex_pc[PC_W-1:IDX_W+1];
    assign e_hit            = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign unused_ex_pc_lsb = bus.ex_pc[0];

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // A valid non-branch that hits the BTB means a stale entry; drop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= 2'b01;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (is_br) begin
            ctr_q[e_idx] <= ctr_next(ctr_q[e_idx], taken);
            if (taken) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= br_tgt;
            end
        end else if (bus.ex_valid && e_hit) begin
            valid_q[e_idx] <= 1'b0;
            ctr_q[e_idx]   <= 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (bus.stat_clr) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (is_br && br_cnt_q != CNT_MAX)
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mp && mp_cnt_q != CNT_MAX)
                mp_cnt_q <= mp_cnt_q + CNT_W'(1);
        end
    end

    assign bus.br_cnt = br_cnt_q;
    assign bus.mp_cnt = mp_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_branch_predict_unit;
    localparam int PC_W  = 16;
    localparam int IMM_W = 9;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int EW    = 1 + PC_W + 1 + PC_W + 1 + CNT_W + CNT_W;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk;
    logic rst_n;
    logic strobe;
    int   checks;
    int   failures;

    logic [EW-1:0]    exp_q[$];
    logic [CNT_W-1:0] m_br;
    logic [CNT_W-1:0] m_mp;

    branch_predict_unit_if #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(
        .PC_W(PC_W), .IMM_W(IMM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cc table rows: {cc, flag{N,Z,V}, expected taken}
    logic [6:0] cc_tab [17] = '{
        7'b000_000_1, 7'b000_010_0, 7'b001_010_1, 7'b001_000_0,
        7'b010_000_1, 7'b010_100_0, 7'b010_010_0, 7'b011_100_1,
        7'b011_000_0, 7'b100_010_1, 7'b100_000_1, 7'b100_100_0,
        7'b101_100_1, 7'b101_010_1, 7'b101_000_0, 7'b110_001_1,
        7'b110_110_0
    };

    // scoreboard / monitor
    task automatic check(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty actual=0 expected=1 at %0t", $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("pred_taken", PC_W'(bus.pred_taken), PC_W'(e[EW-1]));
                check("pred_pc",    bus.pred_pc,           e[EW-2 -: PC_W]);
                check("ex_taken",   PC_W'(bus.ex_taken),   PC_W'(e[EW-2-PC_W]));
                check("ex_target",  bus.ex_target,         e[EW-3-PC_W -: PC_W]);
                check("mispredict", PC_W'(bus.mispredict), PC_W'(e[2*CNT_W]));
                check("br_cnt",     PC_W'(bus.br_cnt),     PC_W'(e[2*CNT_W-1 -: CNT_W]));
                check("mp_cnt",     PC_W'(bus.mp_cnt),     PC_W'(e[CNT_W-1:0]));
            end
        end
    end

    // driver tasks
    task automatic ex_idle();
        bus.ex_valid      = 1'b0;
        bus.ex_pc         = 16'h0000;
        bus.ex_pc_plus_2  = 16'h0002;
        bus.ex_branch_imm = 1'b0;
        bus.ex_branch_reg = 1'b0;
        bus.ex_imm        = '0;
        bus.ex_cc         = 3'b000;
        bus.ex_flag       = 3'b000;
        bus.ex_reg_data   = 16'h0000;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_pc    = 16'h0000;
        bus.stat_clr      = 1'b0;
    endtask

    task automatic ex_set(input logic [15:0] pc, input logic bimm, input logic breg,
                          input logic [8:0] imm, input logic [2:0] cc, input logic [2:0] flag,
                          input logic [15:0] rdata, input logic pt, input logic [15:0] ppc);
        bus.ex_valid      = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_pc_plus_2  = pc + 16'd2;
        bus.ex_branch_imm = bimm;
        bus.ex_branch_reg = breg;
        bus.ex_imm        = imm;
        bus.ex_cc         = cc;
        bus.ex_flag       = flag;
        bus.ex_reg_data   = rdata;
        bus.ex_pred_taken = pt;
        bus.ex_pred_pc    = ppc;
        bus.stat_clr      = 1'b0;
    endtask

    // Applies fetch_pc, queues the expected response for this cycle, then
    // advances past the training edge and updates the statistics model.
    task automatic step(input logic [15:0] fpc, input logic ept, input logic [15:0] eppc,
                        input logic etk, input logic [15:0] etgt, input logic emp);
        logic br;
        bus.fetch_pc = fpc;
        exp_q.push_back({ept, eppc, etk, etgt, emp, m_br, m_mp});
        strobe = 1'b1;
        br = bus.ex_valid & (bus.ex_branch_imm | bus.ex_branch_reg);
        @(posedge clk);
        #1;
        strobe = 1'b0;
        if (bus.stat_clr) begin
            m_br = '0;
            m_mp = '0;
        end else begin
            if (br && m_br != CMAX) m_br = m_br + 1'b1;
            if (emp && m_mp != CMAX) m_mp = m_mp + 1'b1;
        end
        ex_idle();
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks   = 0;
        failures = 0;
        strobe   = 1'b0;
        m_br     = '0;
        m_mp     = '0;
        rst_n    = 1'b0;
        bus.fetch_pc = 16'h0010;
        ex_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);
        // EQ imm branch back to 0x000E, trained twice
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        step(16'h0010, 0, 16'h0012, 1, 16'h000E, 1);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        step(16'h0010, 1, 16'h000E, 1, 16'h000E, 1);
        step(16'h0010, 1, 16'h000E, 0, 16'h0002, 0);
        // third taken, then two not-taken: 11 -> 10 -> 01
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 1, 16'h000E, 0);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b000, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 1);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b000, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 1);
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);
        // retrain 0x0010, register branch at 0x0040, alias 0x0030 misses
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        step(16'h0040, 0, 16'h0042, 1, 16'h000E, 1);
        ex_set(16'h0040, 0, 1, 9'h000, 3'b111, 3'b000, 16'h1234, 0, 16'h0042);
        step(16'h0030, 0, 16'h0032, 1, 16'h1234, 1);
        step(16'h0010, 1, 16'h000E, 0, 16'h0002, 0);
        step(16'h0040, 1, 16'h1234, 0, 16'h0002, 0);
        // imm wins over reg; wraparound targets
        ex_set(16'h0100, 1, 1, 9'h004, 3'b111, 3'b000, 16'h5555, 1, 16'h010A);
        step(16'h0004, 0, 16'h0006, 1, 16'h010A, 0);
        ex_set(16'hFFFC, 1, 0, 9'h002, 3'b111, 3'b000, 16'h0, 1, 16'h0002);
        step(16'h0004, 0, 16'h0006, 1, 16'h0002, 0);
        ex_set(16'hFFFC, 1, 0, 9'h100, 3'b111, 3'b000, 16'h0, 1, 16'h0000);
        step(16'h0004, 0, 16'h0006, 1, 16'hFDFE, 1);
        // invalid slot ignored; valid non-branch with stale prediction
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b111, 3'b000, 16'h0, 1, 16'h000E);
        bus.ex_valid = 1'b0;
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 0);
        ex_set(16'h0010, 0, 0, 9'h000, 3'b111, 3'b000, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 1);
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);
        // invalidation restarted the counter at 01
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        step(16'h0010, 0, 16'h0012, 1, 16'h000E, 1);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b000, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 1);
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);

        // condition codes
        for (int i = 0; i < 17; i++) begin
            logic [6:0] row;
            row = cc_tab[i];
            ex_set(16'h0200, 1, 0, 9'h010, row[6:4], row[3:1], 16'h0, 0, 16'h0202);
            step(16'h0004, 0, 16'h0006, row[0], row[0] ? 16'h0222 : 16'h0202, row[0]);
        end

        // statistics saturation, then clear beating an increment
        for (int i = 0; i < 18; i++) begin
            ex_set(16'h0300, 1, 0, 9'h000, 3'b111, 3'b000, 16'h0, 1, 16'h0302);
            step(16'h0004, 0, 16'h0006, 1, 16'h0302, 0);
        end
        ex_set(16'h0300, 1, 0, 9'h000, 3'b111, 3'b000, 16'h0, 0, 16'h0302);
        bus.stat_clr = 1'b1;
        step(16'h0004, 0, 16'h0006, 1, 16'h0302, 1);
        step(16'h0004, 0, 16'h0006, 0, 16'h0002, 0);

        // strengthen 0x0010 to 11, then reset in the middle of a training cycle
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 1, 16'h000E);
        step(16'h0010, 0, 16'h0012, 1, 16'h000E, 0);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 1, 16'h000E, 0);
        step(16'h0010, 1, 16'h000E, 0, 16'h0002, 0);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ex_idle();
        m_br = '0;
        m_mp = '0;
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b010, 16'h0, 0, 16'h0012);
        step(16'h0010, 0, 16'h0012, 1, 16'h000E, 1);
        step(16'h0010, 1, 16'h000E, 0, 16'h0002, 0);
        ex_set(16'h0010, 1, 0, 9'h1FE, 3'b001, 3'b000, 16'h0, 1, 16'h000E);
        step(16'h0010, 1, 16'h000E, 0, 16'h0012, 1);
        step(16'h0010, 0, 16'h0012, 0, 16'h0002, 0);

        // every queued expectation must have been consumed
        @(negedge clk);
        #1;
        check("queue_drained", PC_W'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
